// File: rtl/cursor_pkg.sv
// Shared definitions for the VT52 cursor controller: command opcodes and helpers.
package cursor_pkg;

    localparam int unsigned CMD_OP_BITS = 3;

    localparam logic [CMD_OP_BITS-1:0] CURSOR_NOP   = 3'd0;
    localparam logic [CMD_OP_BITS-1:0] CURSOR_SET   = 3'd1;
    localparam logic [CMD_OP_BITS-1:0] CURSOR_UP    = 3'd2;
    localparam logic [CMD_OP_BITS-1:0] CURSOR_DOWN  = 3'd3;
    localparam logic [CMD_OP_BITS-1:0] CURSOR_LEFT  = 3'd4;
    localparam logic [CMD_OP_BITS-1:0] CURSOR_RIGHT = 3'd5;
    localparam logic [CMD_OP_BITS-1:0] CURSOR_CR    = 3'd6;
    localparam logic [CMD_OP_BITS-1:0] CURSOR_LF    = 3'd7;

    // Every opcode except NOP counts as cursor activity and restarts the blink,
    // even when the motion is clamped and the cursor does not actually move.
    function automatic logic cmd_restarts(input logic [CMD_OP_BITS-1:0] op);
        return op != CURSOR_NOP;
    endfunction

endpackage

// File: rtl/cursor_blink_timer.sv
// Blink phase generator: counts vblank rising edges and toggles the phase every
// BLINK_FRAMES edges. A restart forces the phase on and clears the frame count.
module cursor_blink_timer #(
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic vblank,
    input  logic restart,
    output logic phase
);

    localparam int unsigned CntW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(BLINK_FRAMES - 1);

    logic            vblank_q;
    logic            vblank_rise;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            phase_q, phase_d;

    assign vblank_rise = vblank & ~vblank_q;

    // Next frame count / phase; restart has priority over a coincident edge.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (vblank_rise) begin
            if (cnt_q == CntLast) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Edge-detect history, frame counter and phase registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vblank_q <= 1'b0;
            cnt_q    <= '0;
            phase_q  <= 1'b1;
        end else begin
            vblank_q <= vblank;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/cursor_ctrl.sv
// VT52 cursor controller: holds the cursor position, executes motion commands
// clamped to the visible screen, requests a scroll on LF at the bottom row and
// produces the registered cursor blink enable for the renderer.
module cursor_ctrl
    import cursor_pkg::*;
#(
    parameter int unsigned ROW_BITS     = 5,
    parameter int unsigned COL_BITS     = 7,
    parameter int unsigned ROWS         = 24,
    parameter int unsigned COLS         = 80,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   vblank,
    input  logic                   cursor_enable,
    input  logic                   cmd_valid,
    input  logic [CMD_OP_BITS-1:0] cmd_op,
    input  logic [COL_BITS-1:0]    cmd_x,
    input  logic [ROW_BITS-1:0]    cmd_y,
    output logic [COL_BITS-1:0]    cursor_x,
    output logic [ROW_BITS-1:0]    cursor_y,
    output logic                   cursor_blink_on,
    output logic                   scroll_req
);

    // Clamp limits are the last visible cell, not the all-ones coordinate.
    localparam logic [COL_BITS-1:0] XMax = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] YMax = ROW_BITS'(ROWS - 1);

    logic [COL_BITS-1:0] x_q, x_d;
    logic [ROW_BITS-1:0] y_q, y_d;
    logic                scroll_q, scroll_d;
    logic                blink_on_q;
    logic                restart;
    logic                phase;

    assign restart = cmd_valid & cmd_restarts(cmd_op);

    cursor_blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk     (clk),
        .reset   (reset),
        .vblank  (vblank),
        .restart (restart),
        .phase   (phase)
    );

    // Decode the command into the next position and the scroll pulse.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        scroll_d = 1'b0;
        if (cmd_valid) begin
            case (cmd_op)
                CURSOR_SET: begin
                    x_d = (cmd_x > XMax) ? XMax : cmd_x;
                    y_d = (cmd_y > YMax) ? YMax : cmd_y;
                end
                CURSOR_UP: begin
                    if (y_q != '0) y_d = y_q - ROW_BITS'(1);
                end
                CURSOR_DOWN: begin
                    if (y_q < YMax) y_d = y_q + ROW_BITS'(1);
                end
                CURSOR_LEFT: begin
                    if (x_q != '0) x_d = x_q - COL_BITS'(1);
                end
                CURSOR_RIGHT: begin
                    if (x_q < XMax) x_d = x_q + COL_BITS'(1);
                end
                CURSOR_CR: begin
                    x_d = '0;
                end
                CURSOR_LF: begin
                    if (y_q < YMax) y_d = y_q + ROW_BITS'(1);
                    else            scroll_d = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Position and scroll request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q      <= '0;
            y_q      <= '0;
            scroll_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            scroll_q <= scroll_d;
        end
    end

    // Registered blink output; the timer keeps running while the cursor is hidden.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_on_q <= 1'b1;
        end else begin
            blink_on_q <= phase & cursor_enable;
        end
    end

    assign cursor_x        = x_q;
    assign cursor_y        = y_q;
    assign scroll_req      = scroll_q;
    assign cursor_blink_on = blink_on_q;

endmodule
